// File: rtl/zipdma_wbmem.sv
// zipdma_wbmem: pipelined Wishbone responder used as the DMA scratch memory.
// Each accepted beat travels through a LATENCY-deep response pipeline and
// comes back as exactly one ACK (or ERR). Byte-selected writes land in memory
// on the accept edge; reads sample memory on the accept edge.
// Optional feature: define ZIPDMA_WBMEM_RANGE_ERR_EN to answer out-of-range
// word addresses with ERR and lock the bus cycle until cyc drops. Without it,
// addresses alias modulo the memory size and o_wb_err is tied low.
module zipdma_wbmem #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int BUS_WIDTH     = 512,
  parameter int LGMEMSZ       = 16,
  parameter int LATENCY       = 2,
  parameter bit OPT_LOWPOWER  = 1'b0,
  localparam int SW = BUS_WIDTH / 8,
  localparam int AW = ADDRESS_WIDTH - $clog2(SW)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [BUS_WIDTH-1:0] i_wb_data,
  input  logic [SW-1:0]        i_wb_sel,
  input  logic                 i_hold,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [BUS_WIDTH-1:0] o_wb_data,
  output logic                 o_wb_err
);

  localparam int IW = LGMEMSZ - $clog2(SW);
  localparam int NW = 1 << IW;

  logic [BUS_WIDTH-1:0] mem [0:NW-1];
  logic [IW-1:0]        idx;
  logic                 accept;
  logic                 bad;
  logic                 err_lock;
  logic                 issue_err;
  logic [LATENCY-1:0]   keep;
  logic [LATENCY-1:0]   ack_q;
  logic [LATENCY-1:0]   ack_nx;
  logic [LATENCY-1:0]   err_q;
  logic [LATENCY-1:0]   err_nx;
  logic [BUS_WIDTH-1:0] dat_q  [0:LATENCY-1];
  logic [BUS_WIDTH-1:0] dat_nx [0:LATENCY-1];

  assign idx        = i_wb_addr[IW-1:0];
  assign o_wb_stall = i_hold || err_lock;
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;

`ifdef ZIPDMA_WBMEM_RANGE_ERR_EN
  // Any address bit at or above the memory index width means out of range.
  assign bad = (i_wb_addr >> IW) != {AW{1'b0}};

  // Error lock: set on the edge that issues an ERR, released once cyc is sampled low.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_lock <= 1'b0;
    end else if (!i_wb_cyc) begin
      err_lock <= 1'b0;
    end else if (err_nx[LATENCY-1]) begin
      err_lock <= 1'b1;
    end
  end

  assign o_wb_err = err_q[LATENCY-1];
`else
  logic unused;

  assign bad      = 1'b0;
  assign err_lock = 1'b0;
  assign o_wb_err = 1'b0;
  assign unused   = &{1'b0, i_wb_addr, err_q};
`endif

  // Next pipeline state: shift, inject the new beat, then apply abort / error-lock clears.
  always_comb begin
    ack_nx    = '0;
    err_nx    = '0;
    keep      = '1;
    issue_err = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      dat_nx[i] = '0;
    end
    ack_nx[0] = accept && !bad;
    err_nx[0] = accept && bad;
    dat_nx[0] = mem[idx];
    for (int i = 1; i < LATENCY; i++) begin
      ack_nx[i] = ack_q[i-1];
      err_nx[i] = err_q[i-1];
      dat_nx[i] = dat_q[i-1];
    end
    issue_err = err_nx[LATENCY-1];
    if (!i_wb_cyc) begin
      keep = '0;
    end else if (issue_err) begin
      // Only the ERR leaving the pipeline survives; everything behind it is dropped.
      keep = '0;
      keep[LATENCY-1] = 1'b1;
    end else begin
      keep = '1;
    end
    ack_nx = ack_nx & keep;
    err_nx = err_nx & keep;
    dat_nx[LATENCY-1] = (OPT_LOWPOWER && !ack_nx[LATENCY-1]) ? {BUS_WIDTH{1'b0}}
                                                             : dat_nx[LATENCY-1];
  end

  // Response pipeline registers; the last stage drives the bus outputs directly.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      ack_q <= ack_nx;
      err_q <= err_nx;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_nx[i];
      end
    end
  end

  assign o_wb_ack  = ack_q[LATENCY-1];
  assign o_wb_data = dat_q[LATENCY-1];

  // Byte-lane writes into the scratch array; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && !bad) begin
      for (int b = 0; b < SW; b++) begin
        if (i_wb_sel[b]) begin
          mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_zipdma_wbmem.sv
// Self-checking bench for zipdma_wbmem: directed scenarios plus randomized
// traffic, compared against a transaction-level reference model (word map
// plus a list of responses due on given clock edges).
module tb_zipdma_wbmem;
  localparam int ADDR_W = 30;
  localparam int BW     = 512;
  localparam int LGM    = 16;
  localparam int LAT    = 2;
  localparam int SW     = BW / 8;
  localparam int AW     = ADDR_W - $clog2(SW);
  localparam int IW     = LGM - $clog2(SW);
  localparam int NW     = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we, hold;
  logic [AW-1:0] addr;
  logic [BW-1:0] wdata, rdata;
  logic [SW-1:0] sel;
  logic          stall, ack, err;

  zipdma_wbmem #(
    .ADDRESS_WIDTH(ADDR_W), .BUS_WIDTH(BW), .LGMEMSZ(LGM),
    .LATENCY(LAT), .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .i_hold(hold),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_wb_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    bit            is_err;
    bit            is_read;
    logic [BW-1:0] data;
  } resp_t;

  int            checks    = 0;
  int            failures  = 0;
  int            edge_n    = 0;
  int            ack_count = 0;
  resp_t         pend[$];
  logic [BW-1:0] mem_m [int];
  bit            lock_m = 1'b0;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < BW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic bit is_bad(input logic [AW-1:0] a);
`ifdef ZIPDMA_WBMEM_RANGE_ERR_EN
    return int'(a) >= NW;
`else
    return (int'(a) < 0);
`endif
  endfunction

  // One bus clock: drive at negedge, update the model at posedge, check at next negedge.
  task automatic beat(input bit c, input bit s, input bit w, input bit h,
                      input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input logic [SW-1:0] m, output bit acc);
    resp_t         r;
    resp_t         hit;
    bit            found;
    int            idx;
    logic [BW-1:0] word;
    cyc = c; stb = s; we = w; hold = h; addr = a; wdata = d; sel = m;
    #1;
    check_eq("stall", BW'(stall), BW'(h || lock_m));
    acc = c && s && !(h || lock_m);
    @(posedge clk);
    edge_n++;
    if (acc) begin
      idx       = int'(a) % NW;
      r.due     = edge_n + LAT - 1;
      r.is_err  = is_bad(a);
      r.is_read = !w;
      if (w && !r.is_err) begin
        word = mem_m.exists(idx) ? mem_m[idx] : {BW{1'bx}};
        for (int b = 0; b < SW; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
        mem_m[idx] = word;
      end
      r.data = mem_m.exists(idx) ? mem_m[idx] : {BW{1'bx}};
      pend.push_back(r);
    end
    found = 1'b0;
    if (!c) begin
      pend.delete();
      lock_m = 1'b0;
    end else begin
      foreach (pend[i]) if (pend[i].due == edge_n && pend[i].is_err) begin
        found = 1'b1;
        hit   = pend[i];
      end
      if (found) begin
        pend.delete();
        pend.push_back(hit);
        lock_m = 1'b1;
      end
    end
    @(negedge clk);
    found = 1'b0;
    foreach (pend[i]) if (pend[i].due == edge_n) begin
      found = 1'b1;
      hit   = pend[i];
    end
    while (pend.size() > 0 && pend[0].due <= edge_n) void'(pend.pop_front());
    check_eq("ack", BW'(ack), BW'(found && !hit.is_err));
    check_eq("err", BW'(err), BW'(found && hit.is_err));
    if (found && !hit.is_err && hit.is_read) check_eq("rdata", rdata, hit.data);
    if (ack) ack_count++;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bit acc;
    beat(1'b1, 1'b1, 1'b0, 1'b0, a, {BW{1'b0}}, {SW{1'b0}}, acc);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d, input logic [SW-1:0] m);
    bit acc;
    beat(1'b1, 1'b1, 1'b1, 1'b0, a, d, m, acc);
  endtask

  task automatic idle(input int n, input bit c);
    bit acc;
    for (int i = 0; i < n; i++) beat(c, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {BW{1'b0}}, {SW{1'b0}}, acc);
  endtask

  initial begin
    bit            acc;
    int            j;
    int            cnt;
    int            ack0;
    logic [7:0]    bv;
    logic [AW-1:0] ra;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; hold = 1'b1;
    addr = '0; wdata = '0; sel = '0;
    #12;
    check_eq("rst_ack", BW'(ack), BW'(1'b0));
    check_eq("rst_err", BW'(err), BW'(1'b0));
    check_eq("rst_data", rdata, {BW{1'b0}});
    check_eq("rst_stall_hold", BW'(stall), BW'(1'b1));
    hold = 1'b0;
    #1;
    check_eq("rst_stall", BW'(stall), BW'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Prefill words 0..15 so every later read has a known value.
    for (int k = 0; k < 16; k++) wr(AW'(k), rand_word(), {SW{1'b1}});
    idle(LAT + 1, 1'b1);
    idle(1, 1'b0);

    // Burst write of 0x11.., 0x22.., 0x33.., 0x44.. then back-to-back burst read.
    for (int k = 0; k < 4; k++) begin
      bv = 8'h11 * 8'(k + 1);
      wr(AW'(k), {SW{bv}}, {SW{1'b1}});
    end
    for (int k = 0; k < 4; k++) rd(AW'(k));
    idle(LAT + 1, 1'b1);
    idle(1, 1'b0);

    // Partial byte write over an all-ones word.
    wr(AW'(5), {SW{8'hFF}}, {SW{1'b1}});
    wr(AW'(5), {SW{8'hAB}}, SW'(1));
    rd(AW'(5));
    idle(LAT + 1, 1'b1);
    check_eq("byte_merge", mem_m[5], {{(SW-1){8'hFF}}, 8'hAB});
    idle(1, 1'b0);

    // 8-beat read burst with i_hold high in cycles 3..5.
    ack0 = ack_count;
    j    = 0;
    cnt  = 1;
    while (j < 8 && cnt <= 40) begin
      beat(1'b1, 1'b1, 1'b0, (cnt >= 3 && cnt <= 5), AW'(j), {BW{1'b0}}, {SW{1'b0}}, acc);
      if (acc) j++;
      cnt++;
    end
    idle(LAT + 1, 1'b1);
    check_eq("hold_beats", BW'(j), BW'(8));
    check_eq("hold_acks", BW'(ack_count - ack0), BW'(8));
    idle(1, 1'b0);

    // Out-of-range address in the middle of a read burst.
    rd(AW'(2));
    rd(AW'(NW + 1));
    rd(AW'(3));
    idle(4, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);

    // Cycle abort with reads in flight, then a fresh cycle.
    rd(AW'(6));
    rd(AW'(7));
    idle(4, 1'b0);
    rd(AW'(1));
    idle(LAT + 1, 1'b1);
    idle(1, 1'b0);

    // Reset asserted with beats pending; memory must keep accepted writes.
    wr(AW'(9), rand_word(), {SW{1'b1}});
    wr(AW'(10), rand_word(), {SW{1'b1}});
    rd(AW'(1));
    rd(AW'(2));
    rd(AW'(3));
    #2;
    check_eq("pre_rst_ack", BW'(ack), BW'(1'b1));
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ack", BW'(ack), BW'(1'b0));
    check_eq("mid_rst_err", BW'(err), BW'(1'b0));
    check_eq("mid_rst_data", rdata, {BW{1'b0}});
    pend.delete();
    lock_m = 1'b0;
    @(negedge clk);
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);
    rd(AW'(9));
    rd(AW'(10));
    idle(LAT + 1, 1'b1);
    idle(1, 1'b0);

    // Randomized traffic, including aliased / out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      ra = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) ra = ra + AW'(NW);
      beat(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ra, rand_word(), {$urandom, $urandom}, acc);
    end
    idle(LAT + 1, 1'b1);
    idle(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
